// File: rtl/dcache_flush_arbiter_if.sv
// Flush-request bundle between the requesters, the arbiter and the dcache.
// Ports: req_i/ack_o (per-requester request level / completion pulse),
//        flush_dcache_o/flush_dcache_ack_i/cache_busy_i (dcache side), busy_o/timeout_o (status).
// Flow: req_i is held until it is consumed by a matching ack_o pulse; the dcache answers with a one-cycle ack.
interface dcache_flush_arbiter_if #(
  parameter int NumReq = 4
);
  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] ack_o;
  logic              flush_dcache_o;
  logic              flush_dcache_ack_i;
  logic              cache_busy_i;
  logic              busy_o;
  logic              timeout_o;

  // master: the arbiter, which drives the flush toward the dcache.
  modport master (
    input  req_i,
    input  flush_dcache_ack_i,
    input  cache_busy_i,
    output ack_o,
    output flush_dcache_o,
    output busy_o,
    output timeout_o
  );

  // slave: the requesters and the dcache, seen as one environment.
  modport slave (
    output req_i,
    output flush_dcache_ack_i,
    output cache_busy_i,
    input  ack_o,
    input  flush_dcache_o,
    input  busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/dcache_flush_arbiter.sv
// Coalesces per-requester dcache flush requests into one flush, with a watchdog on the dcache ack.
// Latency: request seen in IDLE -> flush_dcache_o next cycle; dcache ack -> ack_o two cycles later if the cache is idle.
// Backpressure: requests wait (level held) while a flush is in flight; DRAIN holds off completion while cache_busy_i is high.
// Ports: clk_i, rst_i (sync, active-high); bus (master view of dcache_flush_arbiter_if).
module dcache_flush_arbiter #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_flush_arbiter_if.master bus
);

  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NumReq-1:0] mask_q, mask_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              done_vis;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        // Only requesters present in this cycle join the flush; later ones wait for the next one.
        if (|bus.req_i) begin
          mask_d  = bus.req_i;
          cnt_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The ack is checked first so that an ack on the last watchdog cycle is not reported as a timeout.
        if (bus.flush_dcache_ack_i) begin
          state_d = DRAIN;
        end else if (cnt_q == CntLimit) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DRAIN: begin
        if (!bus.cache_busy_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        mask_d  = '0;
        tmo_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // flush_dcache_o is a pure state decode. The completion and status outputs are also
  // masked by rst_i so an abandoned flush never acknowledges its requesters.
  assign done_vis           = (state_q == DONE) && !rst_i;
  assign bus.flush_dcache_o = (state_q == FLUSH);
  assign bus.ack_o          = done_vis ? mask_q : '0;
  assign bus.timeout_o      = done_vis && tmo_q;
  assign bus.busy_o         = (state_q != IDLE) && !rst_i;

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
module tb_dcache_flush_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dcache_flush_arbiter_if #(.NumReq(4)) bus ();

  dcache_flush_arbiter #(
    .NumReq        (4),
    .TimeoutCycles (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive this cycle's inputs just after the edge, then check its outputs.
  task automatic step(input logic [3:0] req, input logic ack, input logic cbusy, input logic r,
                      input logic eflush, input logic [3:0] eack, input logic ebusy,
                      input logic eto, input string tag);
    @(posedge clk);
    #1;
    bus.req_i              = req;
    bus.flush_dcache_ack_i = ack;
    bus.cache_busy_i       = cbusy;
    rst                    = r;
    #1;
    chk({tag, ".flush"}, {3'b000, bus.flush_dcache_o}, {3'b000, eflush});
    chk({tag, ".ack"}, bus.ack_o, eack);
    chk({tag, ".busy"}, {3'b000, bus.busy_o}, {3'b000, ebusy});
    chk({tag, ".timeout"}, {3'b000, bus.timeout_o}, {3'b000, eto});
  endtask

  initial begin
    bus.req_i              = 4'b0000;
    bus.flush_dcache_ack_i = 1'b0;
    bus.cache_busy_i       = 1'b0;

    // Reset and the cycle after it.
    step(4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, "rst_hold");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "rst_after");

    // Scenario 1: single requester, ack at cycle 5.
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 0, 0, "s1_c0");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s1_c1");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s1_c2");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s1_c3");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s1_c4");
    step(4'b0010, 1, 0, 0, 1, 4'b0000, 1, 0, "s1_c5");
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 1, 0, "s1_c6");
    step(4'b0010, 0, 0, 0, 0, 4'b0010, 1, 0, "s1_c7");
    // Stray dcache ack while idle must be ignored.
    step(4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, "s1_c8");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "s1_c9");

    // Scenario 2: coalescing, late request waits for a second flush.
    step(4'b0101, 0, 0, 0, 0, 4'b0000, 0, 0, "s2_c0");
    step(4'b0101, 0, 0, 0, 1, 4'b0000, 1, 0, "s2_c1");
    step(4'b0111, 0, 0, 0, 1, 4'b0000, 1, 0, "s2_c2");
    step(4'b0111, 0, 0, 0, 1, 4'b0000, 1, 0, "s2_c3");
    step(4'b0111, 1, 0, 0, 1, 4'b0000, 1, 0, "s2_c4");
    step(4'b0111, 0, 0, 0, 0, 4'b0000, 1, 0, "s2_c5");
    step(4'b0111, 0, 0, 0, 0, 4'b0101, 1, 0, "s2_c6");
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 0, 0, "s2_c7");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s2_c8");
    step(4'b0010, 1, 0, 0, 1, 4'b0000, 1, 0, "s2_c9");
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 1, 0, "s2_c10");
    step(4'b0010, 0, 0, 0, 0, 4'b0010, 1, 0, "s2_c11");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "s2_c12");

    // Scenario 3: no ack, watchdog of 8 cycles fires.
    step(4'b1000, 0, 0, 0, 0, 4'b0000, 0, 0, "s3_c0");
    for (int i = 1; i <= 8; i++) begin
      step(4'b1000, 0, 0, 0, 1, 4'b0000, 1, 0, $sformatf("s3_c%0d", i));
    end
    step(4'b1000, 0, 0, 0, 0, 4'b1000, 1, 1, "s3_c9");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "s3_c10");

    // Scenario 4: ack on the last watchdog cycle wins; DRAIN held one cycle by cache_busy.
    step(4'b0001, 0, 0, 0, 0, 4'b0000, 0, 0, "s4_c0");
    for (int i = 1; i <= 7; i++) begin
      step(4'b0001, 0, 0, 0, 1, 4'b0000, 1, 0, $sformatf("s4_c%0d", i));
    end
    step(4'b0001, 1, 0, 0, 1, 4'b0000, 1, 0, "s4_c8");
    step(4'b0001, 0, 1, 0, 0, 4'b0000, 1, 0, "s4_c9");
    step(4'b0001, 0, 0, 0, 0, 4'b0000, 1, 0, "s4_c10");
    step(4'b0001, 0, 0, 0, 0, 4'b0001, 1, 0, "s4_c11");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "s4_c12");

    // Scenario 5: long drain with a stray ack injected during DRAIN.
    step(4'b0100, 0, 0, 0, 0, 4'b0000, 0, 0, "s5_c0");
    step(4'b0100, 0, 0, 0, 1, 4'b0000, 1, 0, "s5_c1");
    step(4'b0100, 0, 0, 0, 1, 4'b0000, 1, 0, "s5_c2");
    step(4'b0100, 1, 0, 0, 1, 4'b0000, 1, 0, "s5_c3");
    step(4'b0100, 0, 1, 0, 0, 4'b0000, 1, 0, "s5_c4");
    step(4'b0100, 0, 1, 0, 0, 4'b0000, 1, 0, "s5_c5");
    step(4'b0100, 1, 1, 0, 0, 4'b0000, 1, 0, "s5_c6");
    step(4'b0100, 0, 1, 0, 0, 4'b0000, 1, 0, "s5_c7");
    step(4'b0100, 0, 1, 0, 0, 4'b0000, 1, 0, "s5_c8");
    step(4'b0100, 0, 1, 0, 0, 4'b0000, 1, 0, "s5_c9");
    step(4'b0100, 0, 0, 0, 0, 4'b0000, 1, 0, "s5_c10");
    step(4'b0100, 0, 0, 0, 0, 4'b0100, 1, 0, "s5_c11");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "s5_c12");

    // Scenario 6: reset during DRAIN abandons the flush; held request restarts from IDLE.
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 0, 0, "s6_c0");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s6_c1");
    step(4'b0010, 1, 0, 0, 1, 4'b0000, 1, 0, "s6_c2");
    step(4'b0010, 0, 1, 0, 0, 4'b0000, 1, 0, "s6_c3");
    step(4'b0010, 0, 1, 0, 0, 4'b0000, 1, 0, "s6_c4");
    step(4'b0010, 0, 1, 0, 0, 4'b0000, 1, 0, "s6_c5");
    step(4'b0010, 0, 1, 1, 0, 4'b0000, 0, 0, "s6_c6");
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 0, 0, "s6_c7");
    step(4'b0010, 0, 0, 0, 1, 4'b0000, 1, 0, "s6_c8");
    step(4'b0010, 1, 0, 0, 1, 4'b0000, 1, 0, "s6_c9");
    step(4'b0010, 0, 0, 0, 0, 4'b0000, 1, 0, "s6_c10");
    step(4'b0010, 0, 0, 0, 0, 4'b0010, 1, 0, "s6_c11");
    step(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, "s6_c12");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_flush_arbiter.md
DCACHE_FLUSH_ARBITER -- requirements
Module: dcache_flush_arbiter

Interface
REQ-001 Parameter NumReq, default 4: number of flush requesters (legal range 2..8).
REQ-002 Parameter TimeoutCycles, default 1024: maximum cycles spent waiting for a flush acknowledge (legal range 2 or more).
REQ-003 clk_i  input  1  clock; the only clock of the block.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 req_i  input  NumReq  per-requester flush request; level, held until consumed.
REQ-006 ack_o  output  NumReq  per-requester completion; single-cycle pulse.
REQ-007 flush_dcache_o  output  1  flush request to the dcache.
REQ-008 flush_dcache_ack_i  input  1  dcache flush done; single-cycle pulse.
REQ-009 cache_busy_i  input  1  cache has outstanding external transactions.
REQ-010 busy_o  output  1  arbiter not idle.
REQ-011 timeout_o  output  1  the flush now completing hit the watchdog; single-cycle pulse.

Function
REQ-012 The FSM SHALL have four states: IDLE, FLUSH, DRAIN and DONE, held in a state register.
REQ-013 In IDLE with req_i != 0, the FSM SHALL capture req_i into mask_q, clear the watchdog counter and enter FLUSH in the next cycle.
REQ-014 In IDLE with req_i == 0, the FSM SHALL stay in IDLE.
REQ-015 flush_dcache_o SHALL be 1 exactly while the state is FLUSH, decoded from the state register only, with no combinational path from any input.
REQ-016 flush_dcache_ack_i SHALL be ignored outside FLUSH.
REQ-017 In FLUSH, when flush_dcache_ack_i = 1, the FSM SHALL go to DRAIN next cycle.
REQ-018 In FLUSH with no ack, the watchdog counter SHALL increment, sized $clog2(TimeoutCycles) bits.
REQ-019 In FLUSH, when counter == TimeoutCycles-1 and there is no ack, the FSM SHALL go directly to DONE and set the timeout flag.
REQ-020 If the ack and the counter limit occur in the same cycle, the ack SHALL win: the FSM goes to DRAIN and the timeout flag stays clear.
REQ-021 In DRAIN, the FSM SHALL go to DONE when cache_busy_i = 0 and otherwise stay in DRAIN indefinitely.
REQ-022 In DONE, ack_o SHALL equal mask_q for exactly one cycle, and ack_o SHALL be 0 in every other state.
REQ-023 In DONE, timeout_o SHALL equal the timeout flag; the FSM then SHALL clear mask_q and the flag and go to IDLE.
REQ-024 A single flush SHALL serve every requester present in mask_q (coalescing).
REQ-025 Requests that rise after the IDLE capture cycle SHALL NOT be added to mask_q and SHALL wait for the next flush.
REQ-026 A request SHALL be consumed in the cycle where req_i[i] = 1 and ack_o[i] = 1; req_i[i] high in any later cycle SHALL be treated as a new request.
REQ-027 busy_o SHALL be 1 whenever the state is not IDLE.
REQ-028 Latency: with req_i rising in IDLE at cycle 0, flush_dcache_o SHALL be 1 from cycle 1.
REQ-029 Latency: with the ack at cycle k and cache_busy_i = 0, flush_dcache_o SHALL be 0 from k+1, ack_o SHALL pulse at k+2, and the state SHALL be IDLE at k+3.
REQ-030 Back-to-back: a request held high through the DONE cycle's following cycle SHALL start a new flush, with flush_dcache_o rising 2 cycles after DONE.
REQ-031 Dropping req_i[i] before ack_o[i] is a protocol violation, and the arbiter SHALL still deliver ack_o per mask_q.

Reset
REQ-032 On rst_i = 1 at a clock edge, the block SHALL set: state IDLE, mask_q 0, watchdog 0, timeout flag 0.
REQ-033 While rst_i = 1 and in the cycle after it, the block SHALL drive flush_dcache_o = 0, ack_o = 0, busy_o = 0 and timeout_o = 0.
REQ-034 Reset during FLUSH, DRAIN or DONE SHALL abandon the operation: no ack_o pulse for the in-flight mask, and flush_dcache_o low in the first post-reset cycle.

Verification
REQ-035 Scenario 1: NumReq=4; req_i=4'b0010 at cycle 0; ack_i at cycle 5; busy=0 -> flush_dcache_o=1 in cycles 1..5; ack_o=4'b0010 at cycle 7 only; timeout_o=0.
REQ-036 Scenario 2: req_i=4'b0101 at cycle 0; req_i[1] rises at cycle 2; ack_i at cycle 4 -> ack_o=4'b0101 at cycle 6; new flush_dcache_o rises at cycle 8; ack_o=4'b0010 after the second ack.
REQ-037 Scenario 3: TimeoutCycles=8; req_i[3]=1; no ack -> flush_dcache_o high in cycles 1..8; DONE at cycle 9 with ack_o=4'b1000 and timeout_o=1; no DRAIN visit.
REQ-038 Scenario 4: TimeoutCycles=8; ack_i at the cycle where counter=7 -> DRAIN entered; timeout_o stays 0 throughout.
REQ-039 Scenario 5: ack_i at cycle 3; cache_busy_i=1 during cycles 4..9 -> ack_o pulses at cycle 11; busy_o=1 in cycles 1..11; an ack_i pulse injected during DRAIN is ignored.
REQ-040 Scenario 6: rst_i asserted in DRAIN at cycle 6 -> flush_dcache_o, ack_o and busy_o are 0 from cycle 7; no ack_o pulse; a req_i still held after reset restarts a flush from IDLE.
